// File: rtl/rx_word_aligner.sv
// Bit-slip word aligner: searches a 2W-bit sliding window for SYNC_PATTERN, then holds the offset.
// Optional macro ALIGN_OUT_REG_EN adds a second data_out/data_out_valid register stage.
module rx_word_aligner #(
    parameter int unsigned W            = 16,
    parameter int unsigned WW           = 4,
    parameter logic [W-1:0] SYNC_PATTERN = W'(16'hF0C3),
    parameter int unsigned LOCK_COUNT   = 4
) (
    input  logic          clks,
    input  logic          reset_n,
    input  logic [W-1:0]  data_in,
    input  logic          data_in_valid,
    input  logic          realign,
    output logic [W-1:0]  data_out,
    output logic          data_out_valid,
    output logic [WW-1:0] offset,
    output logic          locked
);

    localparam int unsigned CW            = 3;
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [CW-1:0] LOCK_CNT    = CW'(LOCK_COUNT);
    localparam logic [WW-1:0] OFF_MAX     = WW'(W - 1);
    localparam bit            LOCK_ON_ONE = (LOCK_COUNT <= 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    prev_q;
    logic [CW-1:0]   match_cnt_q;
    logic [CW-1:0]   match_cnt_d;
    logic [WW-1:0]   offset_d;
    logic            locked_d;

    logic [2*W-1:0]  cat_c;
    logic [W-1:0]    win_c;
    logic            match_c;
    logic [WW-1:0]   slip_c;
    logic [CW-1:0]   cnt_inc_c;

    // Window over {current, previous}; prev supplies the earlier bits.
    assign cat_c     = {data_in, prev_q};
    assign win_c     = cat_c[offset +: W];
    assign match_c   = (win_c == SYNC_PATTERN);
    assign slip_c    = (offset == OFF_MAX) ? '0 : offset + WW'(1);
    assign cnt_inc_c = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + CW'(1);

    // Next-state and alignment bookkeeping; realign overrides any same-cycle word.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset;
        match_cnt_d = match_cnt_q;
        locked_d    = locked;

        if (realign) begin
            state_d     = HUNT;
            offset_d    = '0;
            match_cnt_d = '0;
            locked_d    = 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (data_in_valid) begin
                        if (match_c) begin
                            match_cnt_d = CW'(1);
                            if (LOCK_ON_ONE) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                state_d  = VERIFY;
                            end
                        end else begin
                            offset_d = slip_c;
                        end
                    end
                end
                VERIFY: begin
                    if (data_in_valid) begin
                        if (match_c) begin
                            match_cnt_d = cnt_inc_c;
                            if (cnt_inc_c >= LOCK_CNT) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            state_d     = HUNT;
                            offset_d    = slip_c;
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Mismatches here are payload, not misalignment.
                    state_d = LOCKED;
                end
                default: begin
                    state_d     = HUNT;
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                end
            endcase
        end
    end

    // State, offset, counter and lock flag.
    always_ff @(posedge clks) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            offset      <= '0;
            match_cnt_q <= '0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset      <= offset_d;
            match_cnt_q <= match_cnt_d;
            locked      <= locked_d;
        end
    end

    // Previous-word history loads on every valid word, realign included.
    always_ff @(posedge clks) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else if (data_in_valid) begin
            prev_q <= data_in;
        end
    end

`ifdef ALIGN_OUT_REG_EN
    logic [W-1:0] data_s1_q;
    logic         valid_s1_q;

    // Two-stage output path.
    always_ff @(posedge clks) begin
        if (!reset_n) begin
            data_s1_q      <= '0;
            valid_s1_q     <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_s1_q      <= win_c;
            valid_s1_q     <= data_in_valid;
            data_out       <= data_s1_q;
            data_out_valid <= valid_s1_q;
        end
    end
`else
    // Single-stage output path.
    always_ff @(posedge clks) begin
        if (!reset_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out       <= win_c;
            data_out_valid <= data_in_valid;
        end
    end
`endif

endmodule

// File: tb/tb_rx_word_aligner.sv
// Scoreboard bench for rx_word_aligner: bit-stream reference model, queue-based output monitor.
module tb_rx_word_aligner;

    localparam int unsigned W          = 16;
    localparam int unsigned WW         = 4;
    localparam logic [15:0] SYNC       = 16'hF0C3;
    localparam int          LOCK_COUNT = 4;

    logic          clks = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          realign = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_out_valid;
    logic [WW-1:0] offset;
    logic          locked;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    logic [15:0] m_prev = '0;
    int          m_off = 0;
    int          m_run = 0;
    bit          m_locked = 1'b0;

    rx_word_aligner #(
        .W(W), .WW(WW), .SYNC_PATTERN(SYNC), .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clks(clks),
        .reset_n(reset_n),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .realign(realign),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .offset(offset),
        .locked(locked)
    );

    always #5 clks = ~clks;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Bit j of a stream whose training pattern repeats from bit position p.
    function automatic logic [15:0] word_at(input int k, input int p, input logic [15:0] noise);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            int j;
            j = 16 * k + i;
            r[i] = (j >= p) ? SYNC[(j - p) % 16] : noise[i];
        end
        return r;
    endfunction

    // Sixteen consecutive stream bits starting o bits into the previous word.
    function automatic logic [15:0] model_win(input logic [15:0] prv, input logic [15:0] d, input int o);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = (o + i < 16) ? prv[o + i] : d[o + i - 16];
        end
        return r;
    endfunction

    task automatic cycle(input logic [15:0] d, input logic v, input logic ra, input logic rn);
        logic [15:0] w;
        data_in       = d;
        data_in_valid = v;
        realign       = ra;
        reset_n       = rn;
        if (!rn) begin
            m_prev = '0; m_off = 0; m_run = 0; m_locked = 1'b0;
        end else begin
            w = model_win(m_prev, d, m_off);
            if (v) exp_q.push_back(w);
            if (ra) begin
                m_off = 0; m_run = 0; m_locked = 1'b0;
            end else if (v && !m_locked) begin
                if (w == SYNC) begin
                    m_run++;
                    if (m_run >= LOCK_COUNT) m_locked = 1'b1;
                end else begin
                    m_run = 0;
                    m_off = (m_off + 1) % 16;
                end
            end
            if (v) m_prev = d;
        end
        @(posedge clks);
        #1;
        if (!rn) begin
            exp_q.delete();
            chk("reset_data_out", int'(data_out), 0);
            chk("reset_data_out_valid", int'(data_out_valid), 0);
        end
        chk("offset", int'(offset), m_off);
        chk("locked", int'(locked), int'(m_locked));
    endtask

    task automatic do_reset();
        cycle(16'($urandom), 1'b1, 1'b1, 1'b0);
        data_in_valid = 1'b0;
        realign = 1'b0;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every presented output word must match the next expected one.
    always @(negedge clks) begin
        if (data_out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid: data_out=0x%0h with no word pending at %0t", data_out, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL data_out: got 0x%0h, expected 0x%0h at %0t", data_out, e, $time);
                end
            end
        end
    end

    initial begin
        // Reset state
        cycle(16'h0, 1'b0, 1'b0, 1'b0);
        cycle(16'hFFFF, 1'b1, 1'b0, 1'b0);
        chk("reset_offset", int'(offset), 0);
        chk("reset_locked", int'(locked), 0);

        // Phase 5 acquisition, then realign coincident with a valid word
        for (int k = 0; k <= 60; k++) begin
            cycle(word_at(k, 5, 16'($urandom)), 1'b1, (k == 30), 1'b1);
            if (k == 4) chk("p5_offset_after_w4", int'(offset), 5);
            if (k == 7) chk("p5_not_locked_w7", int'(locked), 0);
            if (k == 8) begin
                chk("p5_locked_w8", int'(locked), 1);
                chk("p5_offset_w8", int'(offset), 5);
            end
            if (k == 30) begin
                chk("realign_offset", int'(offset), 0);
                chk("realign_locked", int'(locked), 0);
            end
        end
        chk("p5_relocked", int'(locked), 1);
        chk("p5_reloffset", int'(offset), 5);

        // Phase 0 acquisition needs a full wrap
        do_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(word_at(k, 0, 16'h0), 1'b1, 1'b0, 1'b1);
            if (k == 0)  chk("p0_offset_w0", int'(offset), 1);
            if (k == 15) chk("p0_offset_wrap", int'(offset), 0);
            if (k == 18) chk("p0_not_locked_w18", int'(locked), 0);
        end
        chk("p0_locked", int'(locked), 1);
        chk("p0_offset", int'(offset), 0);

        // Broken verify at phase 3
        do_reset();
        for (int k = 0; k < 46; k++) begin
            logic [15:0] d;
            d = word_at(k, 3, 16'($urandom));
            if (k == 4) d = d ^ 16'hFFFF;
            cycle(d, 1'b1, 1'b0, 1'b1);
            if (k == 2) chk("bv_offset_w2", int'(offset), 3);
            if (k == 4) begin
                chk("bv_offset_w4", int'(offset), 4);
                chk("bv_locked_w4", int'(locked), 0);
            end
        end
        chk("bv_relocked", int'(locked), 1);
        chk("bv_offset", int'(offset), 3);

        // Gap mid-VERIFY, then reset mid-operation
        do_reset();
        for (int k = 0; k <= 8; k++) cycle(word_at(k, 7, 16'($urandom)), 1'b1, 1'b0, 1'b1);
        for (int g = 0; g < 10; g++) begin
            cycle(16'($urandom), 1'b0, 1'b0, 1'b1);
            chk("gap_no_out_valid", int'(data_out_valid), 0);
        end
        chk("gap_offset", int'(offset), 7);
        cycle(word_at(9, 7, 16'h0), 1'b1, 1'b0, 1'b1);
        chk("gap_not_locked_w9", int'(locked), 0);
        cycle(word_at(10, 7, 16'h0), 1'b1, 1'b0, 1'b1);
        chk("gap_locked_w10", int'(locked), 1);
        cycle(word_at(11, 7, 16'h0), 1'b1, 1'b1, 1'b0);
        chk("midreset_offset", int'(offset), 0);
        chk("midreset_locked", int'(locked), 0);

        // Random phases with random gaps
        for (int it = 0; it < 4; it++) begin
            int p;
            int k;
            p = int'($urandom_range(0, 15));
            do_reset();
            k = 0;
            for (int c = 0; c < 200 && k < 40; c++) begin
                logic v;
                v = ($urandom_range(0, 9) < 8);
                cycle(word_at(k, p, 16'($urandom)), v, 1'b0, 1'b1);
                if (v) k++;
            end
            chk("rnd_locked", int'(locked), 1);
            chk("rnd_offset", int'(offset), p);
        end

        // Random words, sparse valid and realign
        for (int c = 0; c < 300; c++) begin
            cycle(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), 1'b1);
        end

        // Drain
        for (int c = 0; c < 3; c++) cycle(16'h0, 1'b0, 1'b0, 1'b1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_word_aligner.md
# rx_word_aligner

- Sits directly downstream of the serdes receive deserializer and consumes its parallel receive word.
- Recovers word alignment with a sequential bit-slip search for a fixed training pattern, using a 2W-bit sliding window over consecutive words.
- Holds the recovered offset once locked and emits re-aligned words to the Chisel-side link logic.

## Interface
Parameters:
- W, 16, word width; equals 2*NDIVBY of the deserializer.
- WW, 4, offset width, log2(W).
- SYNC_PATTERN, 16'hF0C3, W-bit training word; bit 0 is the earliest received bit.
- LOCK_COUNT, 4, consecutive matching words needed to declare lock (1..7).

Ports:
- clks  input  1  single clock. One clock; reset is synchronous and active-low.
- reset_n  input  1  synchronous active-low reset, sampled on posedge clks.
- data_in  input  W  deserialized word; bit 0 is the oldest bit in time.
- data_in_valid  input  1  data_in carries a new word this cycle.
- realign  input  1  single-cycle request to drop lock and restart the search.
- data_out  output  W  aligned word.
- data_out_valid  output  1  data_out carries a new word.
- offset  output  WW  current bit-slip offset.
- locked  output  1  alignment locked.

## Operation
- **prev register:** holds the last valid data_in. It loads on each data_in_valid, including during realign.
- **Window:** win = {data_in, prev}[offset+W-1 : offset], computed combinationally from the current offset. Offset 0 means the word passes through unshifted.
- **States:** HUNT (reset state), VERIFY, LOCKED. Encoded in 2 bits; the 4th encoding returns to HUNT.
- **HUNT**, on each valid word:
  - win == SYNC_PATTERN: go to VERIFY, match_cnt <= 1.
  - otherwise: offset <= offset+1, wrapping W-1 -> 0.
- **VERIFY**, on each valid word:
  - match: match_cnt+1. When it reaches LOCK_COUNT, go to LOCKED (locked <= 1).
  - mismatch: go to HUNT, offset <= offset+1 with wrap, match_cnt <= 0.
  - LOCK_COUNT == 1 goes HUNT -> LOCKED directly on the first match.
- **LOCKED:** offset is frozen; pattern mismatches are ignored, since they are payload data.
- **realign:** from any state, go to HUNT with offset <= 0, match_cnt <= 0, locked <= 0.
  - realign has priority over a same-cycle valid word; that word's match or slip decision is discarded.
- Words with data_in_valid = 0 change no state, counter or offset.
- data_out is produced in every state; consumers qualify it with locked.
- match_cnt is 3 bits and saturates; it never wraps.

## Timing
- **Reset values:** data_out = 0, data_out_valid = 0, offset = 0, locked = 0, prev = 0, state = HUNT, match_cnt = 0.
- **Latency:** data_out <= win and data_out_valid <= data_in_valid are registered, 1 cycle after the input edge. win uses the offset in effect before any same-edge slip.
- **Slip timing:** a slip decided on valid word N applies first to word N+1.
- **Lock timing:** locked rises on the edge that samples the LOCK_COUNT-th consecutive matching valid word.
- **First word after reset:** prev = 0, so the first word is judged against a half-zero window. A mismatch there is an ordinary slip.
- **Worst-case acquisition:** W + LOCK_COUNT valid words.
- **Reset mid-operation:** reset_n low on any edge restores all reset values on that edge, regardless of data_in_valid or realign.

## Configuration
- **ALIGN_OUT_REG_EN defined:** adds a second register stage on data_out and data_out_valid, giving 2-cycle latency. locked and offset keep their existing 1-edge timing.
- **ALIGN_OUT_REG_EN undefined:** data path latency is 1 cycle, as described above.

## Test plan
- **Phase 5 acquisition:** W = 16, SYNC_PATTERN = 16'hF0C3, LOCK_COUNT = 4; stream with the pattern starting at bit phase 5, valid every cycle.
  - Words 0–4 slip; offset reads 5 after word 4.
  - locked = 1 after the edge sampling word 8.
  - data_out == 16'hF0C3 from then on.
- **Phase 0 acquisition:** pattern at phase 0.
  - Word 0 mismatches because prev = 0, so offset goes to 1.
  - Search wraps 15 -> 0 and locks at offset 0 after 20 valid words.
- **Broken verify:** lock sequence at phase 3 with a corrupted word injected as the 2nd match → state returns to HUNT, offset = 4, locked stays 0; the search then wraps and relocks at 3.
- **Realign vs. valid:** in LOCKED, assert realign together with valid = 1 → next cycle offset = 0, locked = 0, no slip from that word; the pattern then reacquires.
- **Gaps and reset:** hold data_in_valid low for 10 cycles mid-VERIFY → no state change and no spurious data_out_valid. Then pull reset_n low for 1 cycle → all outputs return to reset values on that edge.
